// File: rtl/gcm_aes_stream_ctrl_if.sv
// rtl/gcm_aes_stream_ctrl_if.sv - Key/IV/data and result bus between the GCM stream controller and the AES-GCM core
// master = controller side, slave = core side.
interface gcm_aes_stream_ctrl_if;
   logic [127:0] cii_K;
   logic         cii_ctl_vld;
   logic         cii_IV_vld;
   logic [127:0] dii_data;
   logic [3:0]   dii_data_size;
   logic         dii_data_vld;
   logic         dii_data_type;
   logic         dii_last_word;
   logic         dii_data_not_ready;
   logic [127:0] Out_data;
   logic         Out_vld;
   logic         Tag_vld;
   logic [3:0]   Out_data_size;
   logic         Out_last_word;

   modport master (
      output cii_K, cii_ctl_vld, cii_IV_vld,
      output dii_data, dii_data_size, dii_data_vld, dii_data_type, dii_last_word,
      input  dii_data_not_ready, Out_data, Out_vld, Tag_vld, Out_data_size, Out_last_word
   );

   modport slave (
      input  cii_K, cii_ctl_vld, cii_IV_vld,
      input  dii_data, dii_data_size, dii_data_vld, dii_data_type, dii_last_word,
      output dii_data_not_ready, Out_data, Out_vld, Tag_vld, Out_data_size, Out_last_word
   );
endinterface

// File: rtl/gcm_aes_stream_ctrl.sv
// rtl/gcm_aes_stream_ctrl.sv - Sequences key, IV, AAD and PT into an AES-GCM core and collects ciphertext and tag
// Optional GCM_CTRL_TAG_CHECK_EN adds exp_tag_i / tag_ok_o tag comparison on completion.
module gcm_aes_stream_ctrl #(
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [127:0]       key_i,
   input  logic [127:0]       iv_i,
   input  logic [LEN_W-1:0]   aad_len_i,
   input  logic [LEN_W-1:0]   pt_len_i,
   input  logic [3:0]         aad_last_size_i,
   input  logic [3:0]         pt_last_size_i,
`ifdef GCM_CTRL_TAG_CHECK_EN
   input  logic [127:0]       exp_tag_i,
   output logic               tag_ok_o,
`endif
   input  logic [127:0]       s_data_i,
   input  logic               s_vld_i,
   output logic               s_rdy_o,
   output logic [127:0]       m_data_o,
   output logic [3:0]         m_size_o,
   output logic               m_last_o,
   output logic               m_vld_o,
   output logic [127:0]       tag_o,
   output logic               done_o,
   output logic               busy_o,
   output logic               err_o,
   gcm_aes_stream_ctrl_if.master core
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_KEY      = 3'd1;
   localparam logic [2:0] ST_IV       = 3'd2;
   localparam logic [2:0] ST_AAD      = 3'd3;
   localparam logic [2:0] ST_PT       = 3'd4;
   localparam logic [2:0] ST_WAIT_TAG = 3'd5;
   localparam logic [2:0] ST_DONE     = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [127:0]     key_q, key_d;
   logic [127:0]     iv_q, iv_d;
   logic [LEN_W-1:0] aad_len_q, aad_len_d;
   logic [LEN_W-1:0] pt_len_q, pt_len_d;
   logic [3:0]       aad_last_q, aad_last_d;
   logic [3:0]       pt_last_q, pt_last_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [127:0]     tag_q, tag_d;
   logic             err_q, err_d;
   logic [127:0]     m_data_q, m_data_d;
   logic [3:0]       m_size_q, m_size_d;
   logic             m_last_q, m_last_d;
   logic             m_vld_q, m_vld_d;
`ifdef GCM_CTRL_TAG_CHECK_EN
   logic [127:0]     exp_tag_q, exp_tag_d;
   logic             tag_match;
`endif

   logic             in_phase;
   logic             beat;
   logic             last_beat;
   logic [LEN_W-1:0] phase_len;

   assign in_phase  = (state_q == ST_AAD) || (state_q == ST_PT);
   assign s_rdy_o   = in_phase && !core.dii_data_not_ready;
   assign beat      = s_vld_i && s_rdy_o;
   assign phase_len = (state_q == ST_AAD) ? aad_len_q : pt_len_q;
   // A phase is only entered with a non-zero length, so phase_len - 1 never wraps here.
   assign last_beat = in_phase && (beat_cnt_q == phase_len - LEN_ONE);

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      iv_d       = iv_q;
      aad_len_d  = aad_len_q;
      pt_len_d   = pt_len_q;
      aad_last_d = aad_last_q;
      pt_last_d  = pt_last_q;
      beat_cnt_d = beat_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      tag_d      = tag_q;
      err_d      = 1'b0;
`ifdef GCM_CTRL_TAG_CHECK_EN
      exp_tag_d  = exp_tag_q;
`endif
      // Ciphertext words are forwarded whatever the FSM is doing; tag beats are not.
      m_vld_d    = core.Out_vld && !core.Tag_vld;
      m_data_d   = m_vld_d ? core.Out_data      : m_data_q;
      m_size_d   = m_vld_d ? core.Out_data_size : m_size_q;
      m_last_d   = m_vld_d ? core.Out_last_word : m_last_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if ((aad_len_i != '0) || (pt_len_i != '0)) begin
                  key_d      = key_i;
                  iv_d       = iv_i;
                  aad_len_d  = aad_len_i;
                  pt_len_d   = pt_len_i;
                  aad_last_d = aad_last_size_i;
                  pt_last_d  = pt_last_size_i;
`ifdef GCM_CTRL_TAG_CHECK_EN
                  exp_tag_d  = exp_tag_i;
`endif
                  beat_cnt_d = '0;
                  tmo_cnt_d  = '0;
                  state_d    = ST_KEY;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_KEY: state_d = ST_IV;
         ST_IV:  state_d = (aad_len_q != '0) ? ST_AAD : ST_PT;
         ST_AAD: begin
            if (beat) begin
               if (last_beat) begin
                  beat_cnt_d = '0;
                  state_d    = (pt_len_q != '0) ? ST_PT : ST_WAIT_TAG;
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_ONE;
               end
            end
         end
         ST_PT: begin
            if (beat) begin
               if (last_beat) begin
                  beat_cnt_d = '0;
                  state_d    = ST_WAIT_TAG;
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_ONE;
               end
            end
         end
         ST_WAIT_TAG: begin
            if (core.Tag_vld) begin
               tag_d   = core.Out_data;
               state_d = ST_DONE;
            end else if (tmo_cnt_q == TMO_END) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_ONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         key_q      <= '0;
         iv_q       <= '0;
         aad_len_q  <= '0;
         pt_len_q   <= '0;
         aad_last_q <= '0;
         pt_last_q  <= '0;
         beat_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         tag_q      <= '0;
         err_q      <= 1'b0;
         m_data_q   <= '0;
         m_size_q   <= '0;
         m_last_q   <= 1'b0;
         m_vld_q    <= 1'b0;
`ifdef GCM_CTRL_TAG_CHECK_EN
         exp_tag_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         iv_q       <= iv_d;
         aad_len_q  <= aad_len_d;
         pt_len_q   <= pt_len_d;
         aad_last_q <= aad_last_d;
         pt_last_q  <= pt_last_d;
         beat_cnt_q <= beat_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         tag_q      <= tag_d;
         err_q      <= err_d;
         m_data_q   <= m_data_d;
         m_size_q   <= m_size_d;
         m_last_q   <= m_last_d;
         m_vld_q    <= m_vld_d;
`ifdef GCM_CTRL_TAG_CHECK_EN
         exp_tag_q  <= exp_tag_d;
`endif
      end
   end

   assign core.cii_K         = (state_q == ST_KEY) ? key_q : '0;
   assign core.cii_ctl_vld   = (state_q == ST_KEY);
   assign core.cii_IV_vld    = (state_q == ST_IV);
   assign core.dii_data      = (state_q == ST_IV) ? iv_q : (in_phase ? s_data_i : '0);
   assign core.dii_data_vld  = in_phase && s_vld_i;
   assign core.dii_data_type = (state_q == ST_AAD);
   assign core.dii_data_size = !in_phase ? 4'h0 :
                               !last_beat ? 4'hF :
                               (state_q == ST_AAD) ? aad_last_q : pt_last_q;
   // AAD carries the final-word flag only when there is no plaintext after it.
   assign core.dii_last_word = last_beat && ((state_q == ST_PT) || (pt_len_q == '0));

   assign m_data_o = m_data_q;
   assign m_size_o = m_size_q;
   assign m_last_o = m_last_q;
   assign m_vld_o  = m_vld_q;
   assign tag_o    = tag_q;
   assign done_o   = (state_q == ST_DONE);
   assign busy_o   = (state_q != ST_IDLE);

`ifdef GCM_CTRL_TAG_CHECK_EN
   assign tag_match = (tag_q == exp_tag_q);
   assign tag_ok_o  = done_o && tag_match;
   assign err_o     = err_q || (done_o && !tag_match);
`else
   assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_gcm_aes_stream_ctrl.sv
// tb/tb_gcm_aes_stream_ctrl.sv - Scoreboard bench for gcm_aes_stream_ctrl driven by NIST GCM test cases 3 and 4
module tb_gcm_aes_stream_ctrl;
   localparam int LEN_W   = 8;
   localparam int TIMEOUT = 16;

   localparam logic [127:0] KEY  = 128'hfeffe9928665731c6d6a8f9467308308;
   localparam logic [127:0] IV   = 128'hcafebabefacedbaddecaf888_00000001;
   localparam logic [127:0] TAG3 = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
   localparam logic [127:0] TAG4 = 128'h5bc94fbc3221a5db94fae95ae7121a47;
   localparam logic [127:0] P_TC3 [4] = '{128'hd9313225f88406e5a55909c5aff5269a,
                                          128'h86a7a9531534f7da2e4c303d8a318a72,
                                          128'h1c3c0c95956809532fcf0e2449a6b525,
                                          128'hb16aedf5aa0de657ba637b391aafd255};
   localparam logic [127:0] C_TC3 [4] = '{128'h42831ec2217774244b7221b784d0d49c,
                                          128'he3aa212f2c02a4e035c17e2329aca12e,
                                          128'h21d514b25466931c7d8f6a5aac84aa05,
                                          128'h1ba30b396a0aac973d58e091473f5985};
   localparam logic [127:0] P4_LAST = 128'hb16aedf5aa0de657ba637b39_00000000;
   localparam logic [127:0] C4_LAST = 128'h1ba30b396a0aac973d58e091_00000000;
   localparam logic [127:0] A_TC4 [2] = '{128'hfeedfacedeadbeeffeedfacedeadbeef,
                                          128'habaddad2_000000000000000000000000};

   typedef struct packed { logic [127:0] d; logic [3:0] s; logic l; } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [127:0] key_v = KEY, iv_v = IV;
   logic [LEN_W-1:0] aad_len = '0, pt_len = '0;
   logic [3:0] aad_ls = '0, pt_ls = '0;
   logic [127:0] s_data = '0;
   logic s_vld = 1'b0;
   logic s_rdy_o, m_last_o, m_vld_o, done_o, busy_o, err_o;
   logic [127:0] m_data_o, tag_o;
   logic [3:0] m_size_o;
`ifdef GCM_CTRL_TAG_CHECK_EN
   logic tag_ok_o;
`endif

   logic stall = 1'b0, withhold = 1'b0;
   logic [127:0] core_out_data = '0;
   logic core_out_vld = 1'b0, core_tag_vld = 1'b0, core_out_last = 1'b0;
   logic [3:0] core_out_size = '0;

   logic [127:0] aad_ref [2], pt_ref [4], exp_c [4], ks [4];
   logic [3:0] cur_pt_last;
   exp_t exp_q [$];

   int n_aad, n_pt, tag_wait, last_idx;
   logic bad;
   logic [3:0] aad_size_log [2], pt_size_log [4];

   int chk = 0, pass = 0, done_cnt = 0, err_cnt = 0;
   logic [127:0] tag_at_done = '0;

   gcm_aes_stream_ctrl_if ifc ();
   assign ifc.dii_data_not_ready = stall;
   assign ifc.Out_data           = core_out_data;
   assign ifc.Out_vld            = core_out_vld;
   assign ifc.Tag_vld            = core_tag_vld;
   assign ifc.Out_data_size      = core_out_size;
   assign ifc.Out_last_word      = core_out_last;

   gcm_aes_stream_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start_i(start), .key_i(key_v), .iv_i(iv_v),
      .aad_len_i(aad_len), .pt_len_i(pt_len), .aad_last_size_i(aad_ls), .pt_last_size_i(pt_ls),
`ifdef GCM_CTRL_TAG_CHECK_EN
      .exp_tag_i(128'h0), .tag_ok_o(tag_ok_o),
`endif
      .s_data_i(s_data), .s_vld_i(s_vld), .s_rdy_o(s_rdy_o),
      .m_data_o(m_data_o), .m_size_o(m_size_o), .m_last_o(m_last_o), .m_vld_o(m_vld_o),
      .tag_o(tag_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o), .core(ifc)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] size_mask(input logic [3:0] s);
      logic [127:0] m;
      m = '1;
      return m << (8 * (15 - int'(s)));
   endfunction

   // Core stand-in: keystream XOR for ciphertext, tag released only for the exact NIST word streams.
   always @(posedge clk) begin
      if (rst) begin
         core_out_vld <= 1'b0; core_tag_vld <= 1'b0; core_out_last <= 1'b0;
         core_out_data <= '0; core_out_size <= '0;
         tag_wait <= 0; n_aad <= 0; n_pt <= 0; bad <= 1'b0; last_idx <= 0;
      end else begin
         core_out_vld <= 1'b0; core_tag_vld <= 1'b0; core_out_last <= 1'b0;
         if (ifc.cii_ctl_vld) begin
            bad <= (ifc.cii_K !== KEY); n_aad <= 0; n_pt <= 0; last_idx <= 0;
         end
         if (ifc.cii_IV_vld && ifc.dii_data !== IV) bad <= 1'b1;
         if (ifc.dii_data_vld && !ifc.dii_data_not_ready) begin
            if (ifc.dii_data_type) begin
               if (n_aad < 2) begin
                  if (ifc.dii_data !== aad_ref[n_aad]) bad <= 1'b1;
                  aad_size_log[n_aad] <= ifc.dii_data_size;
               end else bad <= 1'b1;
               n_aad <= n_aad + 1;
            end else begin
               if (n_pt < 4) begin
                  if (ifc.dii_data !== pt_ref[n_pt]) bad <= 1'b1;
                  pt_size_log[n_pt] <= ifc.dii_data_size;
                  core_out_data <= (ifc.dii_data ^ ks[n_pt]) & size_mask(ifc.dii_data_size);
               end else bad <= 1'b1;
               core_out_vld  <= 1'b1;
               core_out_size <= ifc.dii_data_size;
               core_out_last <= ifc.dii_last_word;
               n_pt <= n_pt + 1;
            end
            if (ifc.dii_last_word) begin
               last_idx <= n_aad + n_pt + 1;
               if (!withhold) tag_wait <= 3;
            end
         end
         if (tag_wait != 0) begin
            tag_wait <= tag_wait - 1;
            if (tag_wait == 1) begin
               core_tag_vld <= 1'b1;
               core_out_vld <= 1'b1;
               if (!bad && n_pt == 4 && n_aad == 0)      core_out_data <= TAG3;
               else if (!bad && n_pt == 4 && n_aad == 2) core_out_data <= TAG4;
               else                                      core_out_data <= 128'hbad0;
            end
         end
      end
   end

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_o) begin done_cnt++; tag_at_done = tag_o; end
         if (err_o) err_cnt++;
         if (m_vld_o) begin
            chk++;
            if (exp_q.size() == 0)
               $display("FAIL sb_unexpected: got m_data %h, none expected", m_data_o);
            else begin
               e = exp_q.pop_front();
               if ({m_data_o, m_size_o, m_last_o} !== e)
                  $display("FAIL sb_word: got %h/%h/%b want %h/%h/%b", m_data_o, m_size_o, m_last_o, e.d, e.s, e.l);
               else pass++;
            end
         end
      end
   endtask

   task automatic load_tc3();
      for (int i = 0; i < 4; i++) begin pt_ref[i] = P_TC3[i]; exp_c[i] = C_TC3[i]; end
      cur_pt_last = 4'd15;
   endtask

   task automatic do_start(input int al, input int pl, input logic [3:0] als, input logic [3:0] pls);
      aad_len = LEN_W'(al); pt_len = LEN_W'(pl); aad_ls = als; pt_ls = pls;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drive_words(input int na, input int np, input int stop_at, output int tmo);
      tmo = 0;
      for (int i = 0; i < na + np; i++) begin
         logic ok;
         int w;
         if (i < na) s_data = aad_ref[i];
         else begin
            s_data = pt_ref[i - na];
            exp_q.push_back({exp_c[i - na], (i == na + np - 1) ? cur_pt_last : 4'hF, i == na + np - 1});
         end
         s_vld = 1'b1;
         if (i == stop_at) return;
         ok = 1'b0; w = 0;
         while (!ok && w < 60) begin
            @(negedge clk); ok = s_rdy_o;
            @(posedge clk); #1; w++;
         end
         if (!ok) tmo++;
      end
      s_vld = 1'b0;
   endtask

   task automatic wait_done(input int base, output logic got);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (done_cnt > base) got = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      chk++; if (busy_o !== 1'b0 || s_rdy_o !== 1'b0) $display("FAIL reset_busy_rdy: got %b%b want 00", busy_o, s_rdy_o); else pass++;
      chk++; if ({m_vld_o, done_o, err_o, tag_o} !== '0) $display("FAIL reset_outs: got %b%b%b %h want 0", m_vld_o, done_o, err_o, tag_o); else pass++;
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_tc3(input string nm);
      int base_d, base_e, tmo;
      logic got;
      load_tc3();
      base_d = done_cnt; base_e = err_cnt;
      do_start(0, 4, 4'd0, 4'd15);
      drive_words(0, 4, -1, tmo);
      wait_done(base_d, got);
      repeat (3) begin @(posedge clk); #1; end
      chk++; if (!got || tmo != 0) $display("FAIL %s_complete: got done=%b stalls=%0d want done=1 stalls=0", nm, got, tmo); else pass++;
      chk++; if (tag_at_done !== TAG3) $display("FAIL %s_tag: got %h want %h", nm, tag_at_done, TAG3); else pass++;
      chk++; if (done_cnt - base_d != 1 || err_cnt != base_e) $display("FAIL %s_pulses: got done=%0d err=%0d want 1 0", nm, done_cnt - base_d, err_cnt - base_e); else pass++;
      chk++; if (last_idx != 4 || pt_size_log[0] !== 4'hF) $display("FAIL %s_last: got idx=%0d size0=%h want 4 f", nm, last_idx, pt_size_log[0]); else pass++;
      chk++; if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d left want 0", nm, exp_q.size()); else pass++;
   endtask

   task automatic test_tc4();
      int base_d, tmo;
      logic got;
      load_tc3();
      aad_ref[0] = A_TC4[0]; aad_ref[1] = A_TC4[1];
      pt_ref[3] = P4_LAST; exp_c[3] = C4_LAST; cur_pt_last = 4'd11;
      base_d = done_cnt;
      do_start(2, 4, 4'd3, 4'd11);
      drive_words(2, 4, -1, tmo);
      wait_done(base_d, got);
      repeat (3) begin @(posedge clk); #1; end
      chk++; if (!got || tag_at_done !== TAG4) $display("FAIL tc4_tag: got %h want %h", tag_at_done, TAG4); else pass++;
      chk++; if ({aad_size_log[0], aad_size_log[1]} !== 8'hF3) $display("FAIL tc4_aad_size: got %h%h want f3", aad_size_log[0], aad_size_log[1]); else pass++;
      chk++; if ({pt_size_log[2], pt_size_log[3]} !== 8'hFB) $display("FAIL tc4_pt_size: got %h%h want fb", pt_size_log[2], pt_size_log[3]); else pass++;
      chk++; if (last_idx != 6 || exp_q.size() != 0) $display("FAIL tc4_last: got idx=%0d left=%0d want 6 0", last_idx, exp_q.size()); else pass++;
   endtask

   task automatic test_stall();
      int base_d, tmo, low;
      logic got;
      load_tc3();
      base_d = done_cnt; low = 0;
      do_start(0, 4, 4'd0, 4'd15);
      fork
         drive_words(0, 4, -1, tmo);
         begin
            for (int i = 0; i < 100 && n_pt < 2; i++) @(negedge clk);
            @(posedge clk); #1; stall = 1'b1;
            repeat (5) begin
               @(negedge clk); if (!s_rdy_o) low++;
               @(posedge clk); #1;
            end
            stall = 1'b0;
         end
      join
      wait_done(base_d, got);
      repeat (3) begin @(posedge clk); #1; end
      chk++; if (low != 5) $display("FAIL stall_rdy_low: got %0d want 5", low); else pass++;
      chk++; if (!got || tag_at_done !== TAG3) $display("FAIL stall_tag: got %h want %h", tag_at_done, TAG3); else pass++;
      chk++; if (n_pt != 4 || exp_q.size() != 0) $display("FAIL stall_beats: got %0d left=%0d want 4 0", n_pt, exp_q.size()); else pass++;
   endtask

   task automatic test_zero_len();
      int base_e;
      base_e = err_cnt;
      do_start(0, 0, 4'd0, 4'd0);
      chk++; if (err_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL zero_err: got err=%b busy=%b want 1 0", err_o, busy_o); else pass++;
      @(posedge clk); #1;
      chk++; if (err_o !== 1'b0 || busy_o !== 1'b0 || err_cnt - base_e != 1) $display("FAIL zero_pulse: got err=%b busy=%b n=%0d want 0 0 1", err_o, busy_o, err_cnt - base_e); else pass++;
   endtask

   task automatic test_timeout();
      int tmo, early, base_d;
      logic err16;
      load_tc3();
      withhold = 1'b1; early = 0; err16 = 1'b0; base_d = done_cnt;
      do_start(0, 1, 4'd0, 4'd15);
      drive_words(0, 1, -1, tmo);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         if (k < 16 && err_o) early++;
         if (k == 16) err16 = err_o;
      end
      chk++; if (early != 0 || err16 !== 1'b1) $display("FAIL timeout_err: got early=%0d at16=%b want 0 1", early, err16); else pass++;
      @(posedge clk); #1;
      chk++; if (err_o !== 1'b0 || busy_o !== 1'b0 || done_cnt != base_d) $display("FAIL timeout_idle: got err=%b busy=%b done=%0d want 0 0 0", err_o, busy_o, done_cnt - base_d); else pass++;
      chk++; if (exp_q.size() != 0 || tmo != 0) $display("FAIL timeout_drain: got %0d left want 0", exp_q.size()); else pass++;
      withhold = 1'b0;
   endtask

   task automatic test_reset_mid();
      int tmo, base_d, base_e;
      load_tc3();
      do_start(0, 4, 4'd0, 4'd15);
      drive_words(0, 4, 2, tmo);
      #2 rst = 1'b1;
      #1;
      chk++; if ({busy_o, s_rdy_o, m_vld_o, done_o, err_o, m_last_o} !== '0 || tag_o !== '0 || m_data_o !== '0) $display("FAIL rstmid_outs: got %b%b%b%b%b tag=%h want 0", busy_o, s_rdy_o, m_vld_o, done_o, err_o, tag_o); else pass++;
      chk++; if ({ifc.dii_data_vld, ifc.cii_ctl_vld, ifc.cii_IV_vld, ifc.dii_last_word} !== '0 || ifc.dii_data !== '0) $display("FAIL rstmid_core: got %b%b%b data=%h want 0", ifc.dii_data_vld, ifc.cii_ctl_vld, ifc.cii_IV_vld, ifc.dii_data); else pass++;
      s_vld = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      base_d = done_cnt; base_e = err_cnt;
      repeat (20) begin @(posedge clk); #1; end
      chk++; if (done_cnt != base_d || err_cnt != base_e || m_vld_o !== 1'b0) $display("FAIL rstmid_quiet: got done=%0d err=%0d want 0 0", done_cnt - base_d, err_cnt - base_e); else pass++;
      test_tc3("rstmid_tc3");
   endtask

   initial begin
      for (int i = 0; i < 4; i++) ks[i] = P_TC3[i] ^ C_TC3[i];
      fork monitor(); join_none
      test_reset();
      test_tc3("tc3");
      test_tc4();
      test_stall();
      test_zero_len();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end
endmodule

// File: doc/gcm_aes_stream_ctrl.md
GCM_AES_STREAM_CTRL -- requirements
Module: gcm_aes_stream_ctrl

Interface
REQ-001 The block SHALL take parameter LEN_W, default 8: width of the AAD/PT word-count fields.
REQ-002 The block SHALL take parameter TIMEOUT, default 1024: maximum cycles allowed in WAIT_TAG.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle request; samples key, iv, aad_len, pt_len, aad_last_size, pt_last_size.
REQ-006 key, iv  in  128 each  AES key; 96-bit IV concatenated with 32'h00000001.
REQ-007 aad_len, pt_len  in  LEN_W each  number of 128-bit words.
REQ-008 aad_last_size, pt_last_size  in  4 each  byte count minus 1 of the final word.
REQ-009 s_data / s_vld / s_rdy  in / in / out  128 / 1 / 1  host input stream, AAD words first, then PT words.
REQ-010 m_data / m_size / m_last / m_vld  out  128 / 4 / 1 / 1  ciphertext output stream, no backpressure.
REQ-011 tag / done / busy / err  out  128 / 1 / 1 / 1  captured tag, completion pulse, busy status, error pulse.
REQ-012 Core side: outputs cii_K[128], cii_ctl_vld, cii_IV_vld, dii_data[128], dii_data_size[4], dii_data_vld, dii_data_type, dii_last_word; inputs dii_data_not_ready, Out_data[128], Out_vld, Tag_vld, Out_data_size[4], Out_last_word.

Function
REQ-013 The FSM SHALL have states IDLE, KEY, IV, AAD, PT, WAIT_TAG, DONE.
REQ-014 In IDLE, start with aad_len+pt_len != 0 SHALL latch all config fields and go to KEY; start with both lengths 0 SHALL pulse err for 1 cycle and stay in IDLE.
REQ-015 KEY SHALL drive cii_K=key and cii_ctl_vld=1 for exactly 1 cycle, then go to IV.
REQ-016 IV SHALL drive dii_data=iv and cii_IV_vld=1 for exactly 1 cycle, then go to AAD if aad_len!=0, else to PT.
REQ-017 In AAD/PT: s_rdy = !dii_data_not_ready; dii_data_vld = s_vld; dii_data = s_data; a beat transfers when s_vld && s_rdy.
REQ-018 dii_data_type SHALL be 1 in AAD and 0 in PT.
REQ-019 dii_data_size SHALL be 4'hF except on the last beat of each phase, where it SHALL be aad_last_size or pt_last_size respectively.
REQ-020 dii_last_word SHALL assert on the final PT beat, or on the final AAD beat when pt_len==0.
REQ-021 Each phase SHALL count transferred beats and leave AAD after aad_len beats (to PT, or to WAIT_TAG if pt_len==0), and leave PT after pt_len beats to WAIT_TAG.
REQ-022 Out_vld && !Tag_vld SHALL register Out_data, Out_data_size and Out_last_word onto m_*, with m_vld high for exactly 1 cycle, 1-cycle latency, in any state.
REQ-023 Tag_vld SHALL load Out_data into tag and go to DONE; DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-024 WAIT_TAG SHALL count cycles; on reaching TIMEOUT with no Tag_vld it SHALL pulse err and return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-026 All core-side valid/control outputs SHALL be 0 outside the states named above.

Reset
REQ-027 rst SHALL immediately force IDLE, clear all counters and latched config, and drive every output to 0, including s_rdy, m_vld, tag, done, busy and err.
REQ-028 rst mid-operation SHALL abandon the transfer; no done and no err SHALL follow the abandoned transfer.

Configuration
REQ-029 With GCM_CTRL_TAG_CHECK_EN defined: input exp_tag[128] SHALL be latched on start, and output tag_ok SHALL be 1 with done iff tag==exp_tag, else 0. A mismatch SHALL also pulse err.
REQ-030 Without GCM_CTRL_TAG_CHECK_EN: the exp_tag and tag_ok ports SHALL not exist, and err SHALL come only from REQ-014 and REQ-024.

Verification
REQ-031 The bench SHALL cover each of the following directed scenarios:
- key=feffe9928665731c6d6a8f9467308308, iv=cafebabefacedbaddecaf888_00000001, aad_len=0, pt_len=4, pt_last_size=15, NIST test case 3 PT -> first m_data=42831ec2217774244b7221b784d0d49c, m_last on 4th word, tag=4d5c2af327cd64a62cf35abd2ba6fab4, done once.
- Same key/iv, aad_len=2, aad_last_size=3, pt_len=4, pt_last_size=11 (NIST test case 4) -> dii_data_size 3 on 2nd AAD beat and 11 on 4th PT beat, tag=5bc94fbc3221a5db94fae95ae7121a47.
- Test case 3 with dii_data_not_ready forced high 5 cycles mid-PT -> s_rdy low for those cycles, no beat lost or duplicated, identical tag.
- start with aad_len=0, pt_len=0 -> err pulse 1 cycle, busy stays 0.
- Core model withholding Tag_vld, TIMEOUT=16 -> err 16 cycles after entering WAIT_TAG, then IDLE.
- rst asserted during PT beat 2 -> outputs 0 asynchronously; a following test-case-3 run completes with the correct tag.
